dino_jump_controller: RTL
=========================

# dino_jump_controller

Consumes the slow square-wave game-speed signal from the clock divider and turns it into the T-rex's vertical motion. Edge-detects the speed signal into a one-cycle game tick, runs the run/jump/duck/dead state machine, and integrates jump velocity under gravity once per tick. Sits between the clock divider and the VGA sprite renderer, which reads `dino_y` and the status flags every frame.

## Interface
- `GROUND_Y`, 400: screen row of the dino's feet when on the ground.
- `JUMP_VEL`, 12: initial upward velocity in pixels/tick.
- `GRAVITY`, 1: velocity decrement per tick.
- `MAX_HEIGHT`, 200: height clamp in pixels above ground.

- `clk` in 1: system clock, the same clock that drives the divider.
- `rst` in 1: synchronous, active-high reset.
- `speed` in 1: divided square wave from the clock divider, synchronous to `clk`.
- `jump_btn` in 1: jump / restart button level, already debounced.
- `duck_btn` in 1: duck button level, already debounced.
- `game_over` in 1: collision pulse or level from the collision checker.
- `dino_y` out 10: screen row of the feet, equal to `GROUND_Y - height`.
- `airborne` out 1: high in RISE or FALL.
- `ducking` out 1: high in DUCK.
- `dead` out 1: high in DEAD.
- `tick` out 1: one-cycle game tick, exported for the obstacle scroller.

## Operation
- **Tick generation:** register `speed` into `speed_q`. Compute `tick = speed & ~speed_q`, which fires once per full divider period.
- **Jump request latch:**
  - A rising edge of `jump_btn` sets `jump_pending`.
  - The next tick clears `jump_pending`, whether or not the request was consumed.
  - A press held across ticks produces only one jump.
- **State registers:**
  - `height`: 8-bit unsigned.
  - `vel`: 8-bit signed.
  - `state`: one of RUN, DUCK, RISE, FALL, DEAD.
- **RUN:** at a tick,
  - if `jump_pending`: go to RISE with `vel = JUMP_VEL`;
  - else if `duck_btn`: go to DUCK.
  - Jump wins over duck when both are present.
- **DUCK:** at a tick,
  - if `jump_pending`: go to RISE with `vel = JUMP_VEL`;
  - else if `!duck_btn`: go to RUN.
- **RISE and FALL:** at each tick, compute `h_next = height + vel` in 10-bit signed arithmetic.
  - If `h_next <= 0`: set `height = 0`, `vel = 0`, go to RUN (landing).
  - Otherwise: set `height = min(h_next, MAX_HEIGHT)` and `vel = vel - GRAVITY`.
  - After the update, the state is RISE if the new `vel > 0`, else FALL.
- **Fast fall:** `duck_btn` high at a tick in RISE or FALL forces `vel = min(vel - GRAVITY, -4)`. Ducking is not allowed mid-air.
- **DEAD:**
  - Entered from any state on `game_over` high, on the next `clk` edge, without waiting for a tick.
  - `height` and `vel` are frozen.
  - A rising edge of `jump_btn` in DEAD goes to RUN with `height = 0`, `vel = 0`, and `jump_pending` cleared.
  - This restart edge is not also latched as a jump.
- **Outputs:** all outputs are registered or decoded from registered state.

## Timing
- **Reset values:**
  - `state = RUN`, `height = 0`, `vel = 0`, `speed_q = 0`, `jump_pending = 0`.
  - Outputs: `dino_y = GROUND_Y`, `airborne = ducking = dead = tick = 0`.
- **Reset mid-jump:** returns to ground in one cycle.
- **Tick latency:** `tick` asserts the cycle after `speed` rises. State and height update on the `clk` edge at which `tick` is high, so `dino_y` reflects the new height one cycle after `tick`.
- **Simultaneous events:**
  - `game_over` and `tick` in the same cycle: DEAD wins and height is not updated.
  - `jump_btn` rising edge on a tick cycle: counts as pending for that tick.
- **Trajectory:** with defaults the peak is 78 px at tick 12 and landing is at tick 25. The height is symmetric about the peak.
- **Height clamp:** height never exceeds `MAX_HEIGHT`. `vel` keeps decrementing while clamped.

## Structure
- **Package `dino_pkg`:**
  - State encoding: RUN=0, DUCK=1, RISE=2, FALL=3, DEAD=4, 3 bits.
  - Widths: `HEIGHT_W = 8`, `VEL_W = 8`, `Y_W = 10`.
  - Constant: `FAST_FALL_VEL = -4`.
- **Sub-module `rise_edge_detect`:**
  - One register and an AND gate.
  - Instantiated twice, once for `speed` and once for `jump_btn`.

## Test plan
- **Reset and idle:** hold `rst` for 3 cycles, then toggle `speed` for 10 periods with no buttons. Required: `dino_y` = 400 throughout, exactly one `tick` per `speed` rising edge, `airborne` = 0.
- **Full jump:** pulse `jump_btn` between ticks. Required:
  - `dino_y` = 388 after tick 1.
  - `dino_y` = 322 at the peak (tick 12), with FALL entered at tick 12.
  - `dino_y` = 400 and RUN at tick 25.
- **Held button:** keep `jump_btn` high for 40 ticks. Required: one jump only; stays in RUN after landing.
- **Duck then jump:** hold `duck_btn` for 3 ticks, then press `jump_btn` while still ducking. Required: DUCK at the first tick, RISE with `vel` = 12 at the next tick after the press.
- **Death mid-air:** assert `game_over` on the same cycle as tick 5. Required:
  - `dead` = 1 next cycle.
  - `dino_y` frozen at 400 − 50 = 350.
  - A `jump_btn` edge then gives RUN with `dino_y` = 400.
- **Reset mid-air:** assert `rst` at tick 8. Required: next cycle RUN, `dino_y` = 400, `jump_pending` = 0.

Source files
------------

// File: rtl/dino_pkg.sv
// Shared types and widths for the T-rex vertical-motion controller.
// State encoding is fixed because the sprite renderer decodes it directly.
package dino_pkg;

  localparam int HEIGHT_W = 8;
  localparam int VEL_W    = 8;
  localparam int Y_W      = 10;

  localparam logic signed [VEL_W-1:0] FAST_FALL_VEL = -8'sd4;

  typedef enum logic [2:0] {
    S_RUN  = 3'd0,
    S_DUCK = 3'd1,
    S_RISE = 3'd2,
    S_FALL = 3'd3,
    S_DEAD = 3'd4
  } state_t;

endpackage

// File: rtl/dino_jump_controller_edge.sv
// One-cycle rising-edge detector: a single register and an AND gate.
// Used for the game tick from the divided speed wave and for the jump button.
module rise_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/dino_jump_controller.sv
// Run/duck/jump/dead state machine with per-tick height integration under gravity.
// Feeds the sprite renderer with the feet row and the status flags.
module dino_jump_controller
  import dino_pkg::*;
#(
  parameter int GROUND_Y   = 400,
  parameter int JUMP_VEL   = 12,
  parameter int GRAVITY    = 1,
  parameter int MAX_HEIGHT = 200
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           speed,
  input  logic           jump_btn,
  input  logic           duck_btn,
  input  logic           game_over,
  output logic [Y_W-1:0] dino_y,
  output logic           airborne,
  output logic           ducking,
  output logic           dead,
  output logic           tick
);

  localparam logic signed [VEL_W-1:0] JUMP_V = VEL_W'(JUMP_VEL);
  localparam logic signed [VEL_W-1:0] GRAV_V = VEL_W'(GRAVITY);
  localparam logic signed [Y_W-1:0]   MAX_H  = Y_W'(MAX_HEIGHT);

  state_t                     state, state_next;
  logic [HEIGHT_W-1:0]        height, height_next;
  logic signed [VEL_W-1:0]    vel, vel_next;
  logic                       jump_pending, pending_next;
  logic                       jump_rise;
  logic                       take_jump;
  logic signed [Y_W-1:0]      h_next;
  logic signed [VEL_W-1:0]    vel_dec, vel_air;
  logic                       landing;

  rise_edge_detect u_tick_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (speed),
    .rise (tick)
  );

  rise_edge_detect u_jump_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (jump_btn),
    .rise (jump_rise)
  );

  // A press landing on the tick cycle itself still counts for that tick.
  assign take_jump = jump_pending | jump_rise;

  assign h_next  = $signed({2'b00, height}) + $signed({{(Y_W-VEL_W){vel[VEL_W-1]}}, vel});
  assign landing = h_next[Y_W-1] || (h_next == '0);
  assign vel_dec = vel - GRAV_V;
  assign vel_air = (duck_btn && (vel_dec > FAST_FALL_VEL)) ? FAST_FALL_VEL : vel_dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_RUN;
      height       <= '0;
      vel          <= '0;
      jump_pending <= 1'b0;
    end else begin
      state        <= state_next;
      height       <= height_next;
      vel          <= vel_next;
      jump_pending <= pending_next;
    end
  end

  always_comb begin
    state_next   = state;
    height_next  = height;
    vel_next     = vel;
    pending_next = jump_pending;

    if (tick)
      pending_next = 1'b0;
    else if (jump_rise && (state != S_DEAD))
      pending_next = 1'b1;

    // Collision overrides everything, including a coincident tick.
    if (game_over) begin
      state_next = S_DEAD;
    end else begin
      case (state)
        S_RUN: begin
          if (tick) begin
            if (take_jump) begin
              state_next = S_RISE;
              vel_next   = JUMP_V;
            end else if (duck_btn) begin
              state_next = S_DUCK;
            end
          end
        end
        S_DUCK: begin
          if (tick) begin
            if (take_jump) begin
              state_next = S_RISE;
              vel_next   = JUMP_V;
            end else if (!duck_btn) begin
              state_next = S_RUN;
            end
          end
        end
        S_RISE, S_FALL: begin
          if (tick) begin
            if (landing) begin
              height_next = '0;
              vel_next    = '0;
              state_next  = S_RUN;
            end else begin
              height_next = (h_next > MAX_H) ? HEIGHT_W'(MAX_HEIGHT) : h_next[HEIGHT_W-1:0];
              vel_next    = vel_air;
              state_next  = (!vel_air[VEL_W-1] && (vel_air != '0)) ? S_RISE : S_FALL;
            end
          end
        end
        S_DEAD: begin
          if (jump_rise) begin
            state_next   = S_RUN;
            height_next  = '0;
            vel_next     = '0;
            pending_next = 1'b0;
          end
        end
        default: state_next = S_RUN;
      endcase
    end
  end

  assign dino_y   = Y_W'(GROUND_Y) - {{(Y_W-HEIGHT_W){1'b0}}, height};
  assign airborne = (state == S_RISE) || (state == S_FALL);
  assign ducking  = (state == S_DUCK);
  assign dead     = (state == S_DEAD);

endmodule
